// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: packs UART bytes into 24-bit {opcode, data_hi, data_lo} commands with timeout and overrun reporting
module uart_cmd_assembler #(
    parameter int unsigned TIMEOUT = 52080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        overrun,
    output logic        timeout_err
);
    typedef enum logic [1:0] {B0, B1, B2} state_t;
    localparam logic [19:0] LAST = 20'(TIMEOUT - 1);
    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [7:0]  op_q, op_d, hi_q, hi_d;
    logic [23:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d, clr_q, overrun_q, overrun_d, tout_q, tout_d;
    logic        capture;
    // the pending acknowledge masks rx_rdy, which the receiver still holds high for one more cycle
    assign capture = rx_rdy && !clr_q;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        hi_d      = hi_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        overrun_d = overrun_q;
        tout_d    = 1'b0;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
            overrun_d = 1'b0;
        end
        if (capture) begin
            cnt_d = '0;
            if (state_q == B0) begin
                op_d    = rx_data;
                state_d = B1;
            end else if (state_q == B1) begin
                hi_d    = rx_data;
                state_d = B2;
            end else begin
                state_d = B0;
                if (!cmd_rdy_q || clr_cmd_rdy) begin
                    cmd_d     = {op_q, hi_q, rx_data};
                    cmd_rdy_d = 1'b1;
                    overrun_d = overrun_q;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end else if (state_q != B0) begin
            cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 20'd1;
            state_d = (cnt_q == LAST) ? B0 : state_q;
            tout_d  = (cnt_q == LAST);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= B0;
            cnt_q     <= '0;
            op_q      <= '0;
            hi_q      <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            clr_q     <= 1'b0;
            overrun_q <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            hi_q      <= hi_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            clr_q     <= capture;
            overrun_q <= overrun_d;
            tout_q    <= tout_d;
        end
    end
    assign clr_rx_rdy  = clr_q;
    assign cmd         = cmd_q;
    assign cmd_rdy     = cmd_rdy_q;
    assign overrun     = overrun_q;
    assign timeout_err = tout_q;
endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb_uart_cmd_assembler: directed checks of framing, handshake, timeout, overrun and reset
module tb_uart_cmd_assembler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_rdy = 1'b0;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        overrun;
    logic        timeout_err;
    int          checks = 0;
    int          failures = 0;
    int          pulses = 0;
    int          base;
    logic [23:0] snap_cmd;
    logic        snap_rdy, snap_ovr;
    uart_cmd_assembler #(.TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .overrun(overrun), .timeout_err(timeout_err)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (clr_rx_rdy) pulses++;
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    // receiver model: rx_rdy drops one cycle after the acknowledge pulse
    task automatic send(input logic [7:0] b, input logic clr_with);
        @(negedge clk);
        rx_data = b;
        rx_rdy = 1'b1;
        clr_cmd_rdy = clr_with;
        for (int i = 0; i < 10 && !clr_rx_rdy; i++) begin
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
        end
        if (!clr_rx_rdy) chk("ack_wait", 32'(clr_rx_rdy), 32'd1);
        snap_cmd = cmd;
        snap_rdy = cmd_rdy;
        snap_ovr = overrun;
        @(negedge clk);
        rx_rdy = 1'b0;
    endtask
    task automatic frame(input logic [23:0] f, input logic clr_last);
        send(f[23:16], 1'b0);
        send(f[15:8], 1'b0);
        send(f[7:0], clr_last);
    endtask
    task automatic ack_cmd();
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask
    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_cmd", 32'(cmd), 32'h0);
        chk("rst_rdy", 32'(cmd_rdy), 32'd0);
        chk("rst_ack", 32'(clr_rx_rdy), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_tout", 32'(timeout_err), 32'd0);
        base = pulses;
        frame(24'hA51234, 1'b0);
        chk("basic_cmd", 32'(snap_cmd), 32'hA51234);
        chk("basic_rdy", 32'(snap_rdy), 32'd1);
        chk("basic_pulses", 32'(pulses - base), 32'd3);
        chk("basic_ack_low", 32'(clr_rx_rdy), 32'd0);
        chk("basic_ovr", 32'(overrun), 32'd0);
        ack_cmd();
        chk("clear_rdy", 32'(cmd_rdy), 32'd0);
        chk("clear_cmd_held", 32'(cmd), 32'hA51234);
        base = pulses;
        send(8'hC1, 1'b0);
        chk("held_b1_rdy", 32'(snap_rdy), 32'd0);
        send(8'hC2, 1'b0);
        chk("held_b2_rdy", 32'(snap_rdy), 32'd0);
        send(8'hC3, 1'b0);
        chk("held_cmd", 32'(snap_cmd), 32'hC1C2C3);
        chk("held_pulses", 32'(pulses - base), 32'd3);
        ack_cmd();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        repeat (98) @(negedge clk);
        chk("tout_early", 32'(timeout_err), 32'd0);
        @(negedge clk);
        chk("tout_pulse", 32'(timeout_err), 32'd1);
        chk("tout_rdy", 32'(cmd_rdy), 32'd0);
        @(negedge clk);
        chk("tout_single", 32'(timeout_err), 32'd0);
        frame(24'h010203, 1'b0);
        chk("after_tout_cmd", 32'(snap_cmd), 32'h010203);
        ack_cmd();
        frame(24'hAABBCC, 1'b0);
        chk("ovr_first", 32'(snap_cmd), 32'hAABBCC);
        chk("ovr_first_flag", 32'(snap_ovr), 32'd0);
        frame(24'h010203, 1'b0);
        chk("ovr_cmd_held", 32'(snap_cmd), 32'hAABBCC);
        chk("ovr_rdy", 32'(snap_rdy), 32'd1);
        chk("ovr_flag", 32'(snap_ovr), 32'd1);
        ack_cmd();
        chk("ovr_clr_rdy", 32'(cmd_rdy), 32'd0);
        chk("ovr_clr_flag", 32'(overrun), 32'd0);
        frame(24'h112233, 1'b0);
        frame(24'h0A0B0C, 1'b1);
        chk("simul_cmd", 32'(snap_cmd), 32'h0A0B0C);
        chk("simul_rdy", 32'(snap_rdy), 32'd1);
        chk("simul_ovr", 32'(snap_ovr), 32'd0);
        send(8'h77, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_cmd", 32'(cmd), 32'h0);
        chk("mrst_rdy", 32'(cmd_rdy), 32'd0);
        chk("mrst_ovr", 32'(overrun), 32'd0);
        chk("mrst_ack", 32'(clr_rx_rdy), 32'd0);
        chk("mrst_tout", 32'(timeout_err), 32'd0);
        frame(24'h556677, 1'b0);
        chk("mrst_frame", 32'(snap_cmd), 32'h556677);
        chk("mrst_frame_rdy", 32'(snap_rdy), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_cmd_assembler.md
# uart_cmd_assembler

Sits directly downstream of the UART receiver and turns its byte stream into 24-bit commands. Each command is one opcode byte followed by a high data byte and a low data byte. The block consumes each received byte through the receiver's `rx_rdy`/`clr_rx_rdy` handshake and discards partial frames after an inter-byte timeout. It presents completed commands on a held `cmd`/`cmd_rdy` interface, and reports overrun when a newer frame completes before the consumer has cleared the current one.

## Interface
- `TIMEOUT`, default 52080, is the number of idle cycles allowed between bytes of one frame (about two byte times at 2604 clk/bit). Legal range is 2 to 2^20-1; the counter is 20 bits.
- `clk`, input, 1 bit: system clock. All logic is on the rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `rx_data`, input, 8 bits: byte from the UART receiver. Valid while `rx_rdy` is high.
- `rx_rdy`, input, 1 bit: receiver byte-ready flag. It is level-held until the receiver sees `clr_rx_rdy`.
- `clr_rx_rdy`, output, 1 bit: one-cycle registered pulse that acknowledges a captured byte.
- `cmd`, output, 24 bits: `{opcode, data_hi, data_lo}`. Held stable while `cmd_rdy` is high.
- `cmd_rdy`, output, 1 bit: command valid. Set on frame completion; cleared by `clr_cmd_rdy`.
- `clr_cmd_rdy`, input, 1 bit: consumer acknowledge, sampled every cycle.
- `overrun`, output, 1 bit: sticky flag. A frame was dropped because `cmd_rdy` was still set.
- `timeout_err`, output, 1 bit: one-cycle pulse. A partial frame was discarded.

## Operation
- **Byte capture.** A byte is captured in cycle N when `rx_rdy=1` and `clr_rx_rdy=0`.
  - The capturing edge registers `clr_rx_rdy=1` for cycle N+1 only.
  - The `clr_rx_rdy` term in the capture condition blocks double capture, because the receiver's `rx_rdy` is still high in N+1.
- **Collector FSM**, states `B0`, `B1`, `B2`:
  - `B0`: a capture stores `rx_data` in `op_r`, then go to `B1`.
  - `B1`: a capture stores `rx_data` in `hi_r`, then go to `B2`.
  - `B2`: a capture completes the frame (`{op_r, hi_r, rx_data}`), then go to `B0`.
  - The collector keeps running while `cmd_rdy=1`, so it double-buffers the next frame.
- **Frame completion**, decided at the `B2` capture edge:
  - If `cmd_rdy=0`, or `clr_cmd_rdy=1` in the same cycle: load `cmd`, set `cmd_rdy=1`, and leave `overrun` unchanged.
  - Otherwise: `cmd` and `cmd_rdy` are held, the new frame is dropped, and `overrun` is set to 1.
- **`clr_cmd_rdy`** without a simultaneous completion clears `cmd_rdy` and `overrun` at the next edge. `cmd` keeps its value.
- **Timeout.**
  - A 20-bit idle counter is 0 in `B0` and reset to 0 on every capture.
  - In `B1` and `B2` it increments each cycle that has no capture.
  - If it equals `TIMEOUT-1` in a non-capturing cycle, the next edge returns the collector to `B0`, clears the counter, and pulses `timeout_err` for one cycle.
  - A capture in the terminal cycle wins: it is a normal capture with no timeout.
- **Reset** (any cycle, including mid-frame):
  - Collector goes to `B0` and the counter and staging registers go to 0.
  - `cmd=24'h0`, `cmd_rdy=0`, `clr_rx_rdy=0`, `overrun=0`, `timeout_err=0`.
  - A partial frame is lost, with no `timeout_err`.

## Timing
- `clr_rx_rdy` is high in cycle N+1 after capture cycle N. Exactly one pulse is produced per byte.
- `cmd` and `cmd_rdy` are valid in cycle N+1 after the third-byte capture in cycle N, the same cycle as that byte's `clr_rx_rdy`.
- `cmd_rdy` falls in cycle M+1 after `clr_cmd_rdy` is seen in cycle M.
- `overrun` rises in cycle N+1 after a dropped completion in cycle N.
- `timeout_err` is high in cycle N+TIMEOUT+1, where N is the last capture cycle of the partial frame.
- Minimum spacing between captures is 2 cycles; the receiver's real spacing is about 26k cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
Bench uses `TIMEOUT=100` and models the receiver: `rx_rdy` clears one cycle after `clr_rx_rdy`.
- **Basic frame.** Reset, then bytes `0xA5`, `0x12`, `0x34`.
  - `cmd=24'hA51234` and `cmd_rdy=1` one cycle after the third capture.
  - Exactly 3 single-cycle `clr_rx_rdy` pulses; `overrun=0`.
- **Held `rx_rdy`.** `rx_rdy` is held high 2 cycles per byte.
  - Each byte is captured once; the collector advances exactly one state per byte.
- **Timeout.** Send `0x11`, `0x22`, then idle 100 cycles.
  - `timeout_err` pulses in cycle N+101 and `cmd_rdy` stays 0.
  - Then send `0x01`, `0x02`, `0x03`: `cmd=24'h010203`.
- **Overrun.** Frame `0xAABBCC` completes and is not cleared; frame `0x010203` then completes.
  - `cmd` stays `24'hAABBCC` and `overrun=1`.
  - `clr_cmd_rdy` then gives `cmd_rdy=0` and `overrun=0`.
- **Simultaneous clear.** `clr_cmd_rdy` is asserted in the same cycle as the third-byte capture of frame `0x0A0B0C`.
  - `cmd=24'h0A0B0C`, `cmd_rdy` stays 1, `overrun=0`.
- **Reset mid-frame.** After one byte `0x77`, assert `rst` for 1 cycle; all outputs read 0.
  - Then send `0x55`, `0x66`, `0x77`: `cmd=24'h556677`.
